// File: rtl/lc3b_types.sv
// Shared LC-3b bus types plus the state encoding used by the line memory responder.
package lc3b_types;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned DATBUS_W  = 128;
  localparam int unsigned LAT_CNT_W = 8;

  typedef logic [WORD_W-1:0]   lc3b_word;
  typedef logic [DATBUS_W-1:0] lc3b_datbus;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_e;

endpackage

// File: rtl/line_mem_responder_line_array.sv
// Line storage: synchronous write, index-addressed combinational read, cleared on reset.
module line_array
  import lc3b_types::*;
#(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] windex,
  input  lc3b_datbus            wdata,
  input  logic [INDEX_BITS-1:0] rindex,
  output lc3b_datbus            rdata_c
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;

  lc3b_datbus lines_q [DEPTH];
  lc3b_datbus lines_d [DEPTH];

  always_comb begin
    lines_d = lines_q;
    if (we) lines_d[windex] = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) lines_q <= '{default: '0};
    else       lines_q <= lines_d;
  end

  assign rdata_c = lines_q[rindex];

endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency line memory responder: accepts one read/write, answers LATENCY cycles later.
module line_mem_responder
  import lc3b_types::*;
#(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  lc3b_word   pmem_address,
  input  logic       pmem_read,
  input  logic       pmem_write,
  input  lc3b_datbus pmem_wdata,
  output lc3b_datbus pmem_rdata,
  output logic       pmem_resp,
  output logic       pmem_error
);

  pmem_state_e           state_q, state_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [INDEX_BITS-1:0] index_q, index_d;
  lc3b_datbus            wdata_q, wdata_d;
  lc3b_datbus            rdata_q, rdata_d;
  logic                  resp_q, resp_d;
  logic                  error_q, error_d;
  logic                  enter_resp_c;
  logic                  arr_we_c;
  lc3b_datbus            arr_rdata_c;
  logic                  addr_unused_c;

  // Line offset and high address bits only alias; they never affect behaviour.
  assign addr_unused_c = ^pmem_address;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    err_d        = err_q;
    index_d      = index_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    resp_d       = 1'b0;
    error_d      = 1'b0;
    enter_resp_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          write_d = pmem_write;
          err_d   = pmem_read && pmem_write;
          index_d = pmem_address[3+INDEX_BITS:4];
          wdata_d = pmem_wdata;
          cnt_d   = LAT_CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d      = RESP;
            enter_resp_c = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - LAT_CNT_W'(1);
        if (cnt_q == LAT_CNT_W'(1)) begin
          state_d      = RESP;
          enter_resp_c = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The _d operation fields hold either the freshly latched request (LATENCY=1) or the stored one.
    if (enter_resp_c) begin
      resp_d  = 1'b1;
      error_d = err_d;
      if (!write_d) rdata_d = arr_rdata_c;
    end
  end

  assign arr_we_c = enter_resp_c && write_d;

  line_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_line_array (
    .clk    (clk),
    .reset  (reset),
    .we     (arr_we_c),
    .windex (index_d),
    .wdata  (wdata_d),
    .rindex (index_d),
    .rdata_c(arr_rdata_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      index_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      err_q   <= err_d;
      index_q <= index_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      error_q <= error_d;
    end
  end

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = resp_q;
  assign pmem_error = error_q;

endmodule
